lstm_seq_ctrl: RTL and testbench
================================

# lstm_seq_ctrl

Sequencing controller for the combinational LSTM processing element. It runs one LSTM layer over a sequence of `seq_len` time steps. It owns the recurrent state registers (h, c), feeds them to the PE together with each accepted input vector, and waits a fixed settle window for the PE's combinational path. It then captures `c_next`/`h_t`, streams `h_t` out over a valid/ready handshake, and feeds the new state back for the next step. Weights and bias bypass this block and drive the PE directly from the weight store.

## Interface
Parameters:
- `VEC` — default 100 — vector length (PE hidden/input size).
- `SETTLE_CYCLES` — default 4 — cycles allowed for PE combinational settle; legal range ≥1.
- `LEN_W` — default 16 — width of sequence length and step index.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — begin a sequence; sampled only in IDLE.
- `seq_len` in LEN_W — number of time steps; latched when `start` is accepted.
- `x_valid` in 1 / `x_ready` out 1 / `x_data` in [VEC]×32 signed — input vector stream.
- `pe_x`, `pe_h_prev`, `pe_c_prev` out [VEC]×32 signed — driven to PE `x`, `h_prev`, `c_prev`.
- `pe_c_next`, `pe_h_t` in [VEC]×32 signed — PE results.
- `h_valid` out 1 / `h_ready` in 1 / `h_data` out [VEC]×32 signed — output hidden-state stream.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at sequence end.
- `step_idx` out LEN_W — index of the current step, 0-based.

## Operation
- Registers: `x_reg`, `h_reg`, `c_reg` ([VEC]×32); `len_reg`, `step_idx`, `cnt`.
- Datapath connections: `pe_x`=`x_reg`, `pe_h_prev`=`h_reg`, `pe_c_prev`=`c_reg`, `h_data`=`h_reg`.
- States: IDLE, WAIT_X, SETTLE, OUT, DONE.
- IDLE:
  - On `start` with `seq_len`≠0: latch `len_reg`, set `step_idx`=0, clear `h_reg`/`c_reg` (see Configuration), go to WAIT_X.
  - On `start` with `seq_len`=0: go to DONE with no data transfer.
- WAIT_X:
  - `x_ready`=1.
  - On `x_valid`: capture `x_data` into `x_reg`, load `cnt`=SETTLE_CYCLES−1, go to SETTLE.
- SETTLE:
  - `cnt`≠0: decrement.
  - `cnt`=0: capture `pe_c_next`→`c_reg` and `pe_h_t`→`h_reg`, go to OUT.
- OUT:
  - `h_valid`=1; `h_data` is held stable until accepted.
  - On `h_ready`: if `step_idx`=`len_reg`−1, go to DONE; else increment `step_idx` and go to WAIT_X.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`.
- `x_data` and `pe_*` inputs are ignored outside WAIT_X and the final SETTLE cycle respectively.
- No arithmetic in this block besides `cnt`/`step_idx` counters. All data is passed through unmodified at 32-bit signed width.

## Timing
- Reset (async assert, sync deassert by system):
  - State IDLE.
  - All data registers 0, `step_idx`=0.
  - `x_ready`=`h_valid`=`busy`=`done`=0.
- Start to `x_ready`: 1 cycle after the accepting edge.
- Per-step latency: `h_valid` rises exactly SETTLE_CYCLES cycles after the `x_valid`&&`x_ready` edge.
- Step throughput, zero backpressure: SETTLE_CYCLES+2 cycles per step.
- Handshakes:
  - A transfer occurs on a rising edge with valid&&ready.
  - `h_valid` stays asserted and `h_data` stays unchanged until `h_ready`.
  - `x_ready` never depends combinationally on `x_valid`.
- Done timing: `done` pulses the cycle after the final `h` transfer; `busy` falls with it.
- Reset mid-sequence:
  - Immediate abort to IDLE with all registers cleared.
  - No `done` pulse; any partially captured x is discarded.
- `seq_len` is sampled only at start; later changes have no effect.

## Configuration
- `LSTM_CARRY_STATE_EN`:
  - Defined: `h_reg`/`c_reg` are NOT cleared at start, so a new sequence continues from the final state of the previous one (stateful streaming). Reset still clears them.
  - Undefined (default): `h_reg`/`c_reg` clear to 0 on every accepted `start`.

## Test plan
Bench uses VEC=4, SETTLE_CYCLES=3, and a PE stub with `c_next`=`c_prev`+`x` and `h_t`=`c_next`.
- Single step:
  - Stimulus: `start`, `seq_len`=1, `x`={1,2,3,4}, `h_ready`=1.
  - Response: `h_valid` 3 cycles after x accept, `h_data`={1,2,3,4}; `done` pulses one cycle later; `busy` then 0.
- Recurrence:
  - Stimulus: `seq_len`=3, `x`={1,1,1,1} each step.
  - Response: `h_data` outputs {1,…}, {2,…}, {3,…}; `step_idx` reads 0, 1, 2.
- Backpressure:
  - Stimulus: hold `h_ready`=0 for 5 cycles in OUT.
  - Response: `h_valid` held high and `h_data` unchanged for those 5 cycles; no new `x_ready` until the transfer.
- Zero length:
  - Stimulus: `start`, `seq_len`=0.
  - Response: no `x_ready`; `done` pulses on the cycle after start.
- Reset and ignored start:
  - Stimulus: `rst_n` low during SETTLE of step 1 of 3.
  - Response: all outputs 0 immediately; no `done`.
  - Stimulus: `start` asserted while busy.
  - Response: ignored.
- State carry:
  - Stimulus: two back-to-back `seq_len`=1 runs with `x`={5,5,5,5}.
  - Response: second run outputs {10,…} with `LSTM_CARRY_STATE_EN` defined, {5,…} without it.

Source files
------------

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps the combinational LSTM PE over a sequence, owning h/c state.
// Define LSTM_CARRY_STATE_EN to keep h/c across sequences instead of clearing on start.
module lstm_seq_ctrl #(
    parameter int VEC           = 100,
    parameter int SETTLE_CYCLES = 4,
    parameter int LEN_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [LEN_W-1:0]             seq_len,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic signed [VEC-1:0][31:0]  x_data,
    output logic signed [VEC-1:0][31:0]  pe_x,
    output logic signed [VEC-1:0][31:0]  pe_h_prev,
    output logic signed [VEC-1:0][31:0]  pe_c_prev,
    input  logic signed [VEC-1:0][31:0]  pe_c_next,
    input  logic signed [VEC-1:0][31:0]  pe_h_t,
    output logic                         h_valid,
    input  logic                         h_ready,
    output logic signed [VEC-1:0][31:0]  h_data,
    output logic                         busy,
    output logic                         done,
    output logic [LEN_W-1:0]             step_idx
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

`ifdef LSTM_CARRY_STATE_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_X,
        SETTLE,
        OUT,
        DONE
    } state_t;

    state_t                       state;
    logic signed [VEC-1:0][31:0]  x_reg;
    logic signed [VEC-1:0][31:0]  h_reg;
    logic signed [VEC-1:0][31:0]  c_reg;
    logic [LEN_W-1:0]             len_reg;
    logic [CNT_W-1:0]             cnt;

    assign pe_x      = x_reg;
    assign pe_h_prev = h_reg;
    assign pe_c_prev = c_reg;
    assign h_data    = h_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_reg    <= '0;
            h_reg    <= '0;
            c_reg    <= '0;
            len_reg  <= '0;
            step_idx <= '0;
            cnt      <= '0;
            x_ready  <= 1'b0;
            h_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (seq_len != '0) begin
                            len_reg  <= seq_len;
                            step_idx <= '0;
                            x_ready  <= 1'b1;
                            state    <= WAIT_X;
                            if (!CARRY) begin
                                h_reg <= '0;
                                c_reg <= '0;
                            end
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WAIT_X: begin
                    if (x_valid) begin
                        x_reg   <= x_data;
                        cnt     <= CNT_INIT;
                        x_ready <= 1'b0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        c_reg   <= pe_c_next;
                        h_reg   <= pe_h_t;
                        h_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (h_ready) begin
                        h_valid <= 1'b0;
                        if (step_idx == len_reg - LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            step_idx <= step_idx + LEN_W'(1);
                            x_ready  <= 1'b1;
                            state    <= WAIT_X;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: directed literal checks plus random traffic
// compared every cycle against a transaction-level model.
module tb_lstm_seq_ctrl;

    localparam int VEC = 4;
    localparam int S   = 3;
    localparam int LW  = 16;

`ifdef LSTM_CARRY_STATE_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [LW-1:0] seq_len = '0;
    logic x_valid = 1'b0;
    logic x_ready;
    logic signed [VEC-1:0][31:0] x_data = '0;
    logic signed [VEC-1:0][31:0] pe_x, pe_h_prev, pe_c_prev;
    logic signed [VEC-1:0][31:0] pe_c_next, pe_h_t;
    logic h_valid;
    logic h_ready = 1'b0;
    logic signed [VEC-1:0][31:0] h_data;
    logic busy, done;
    logic [LW-1:0] step_idx;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    lstm_seq_ctrl #(.VEC(VEC), .SETTLE_CYCLES(S), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .pe_x(pe_x), .pe_h_prev(pe_h_prev), .pe_c_prev(pe_c_prev),
        .pe_c_next(pe_c_next), .pe_h_t(pe_h_t),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data),
        .busy(busy), .done(done), .step_idx(step_idx)
    );

    // PE stub: c_next = c_prev + x, h_t = c_next
    always_comb begin
        pe_c_next = '0;
        for (int i = 0; i < VEC; i++)
            pe_c_next[i] = pe_c_prev[i] + pe_x[i];
        pe_h_t = pe_c_next;
    end

    // Transaction-level model
    bit m_active = 0, m_xr = 0, m_hv = 0, m_done = 0;
    int m_wait = 0;
    logic [LW-1:0] m_len = '0, m_step = '0;
    logic [VEC-1:0][31:0] m_x = '0, m_h = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_xr <= 0; m_hv <= 0; m_done <= 0;
            m_wait <= 0; m_len <= '0; m_step <= '0; m_x <= '0; m_h <= '0;
        end else if (m_done) begin
            m_done <= 0;
            m_active <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1;
                if (seq_len == 0) begin
                    m_done <= 1;
                end else begin
                    m_len <= seq_len;
                    m_step <= '0;
                    m_xr <= 1;
                    if (!CARRY) m_h <= '0;
                end
            end
        end else if (m_xr) begin
            if (x_valid) begin
                m_xr <= 0;
                m_x <= x_data;
                m_wait <= S;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                for (int i = 0; i < VEC; i++) m_h[i] <= m_h[i] + m_x[i];
                m_hv <= 1;
            end
        end else if (m_hv && h_ready) begin
            m_hv <= 0;
            if (m_step == m_len - 1) m_done <= 1;
            else begin
                m_step <= m_step + 1;
                m_xr <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("m_busy", busy, m_active);
            chk("m_x_ready", x_ready, m_xr);
            chk("m_h_valid", h_valid, m_hv);
            chk("m_done", done, m_done);
            chk("m_step_idx", step_idx, m_step);
            chk("m_h_data", h_data, m_h);
            chk("m_pe_c_prev", pe_c_prev, m_h);
            chk("m_pe_x", pe_x, m_x);
        end
    end

    function automatic logic [127:0] vec4(input int a, input int b, input int c, input int d);
        logic [VEC-1:0][31:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int sel, input string name);
        int n;
        n = 0;
        while (n < 60 && !((sel == 0 && x_ready) || (sel == 1 && h_valid) || (sel == 2 && done))) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL timeout %s", name);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_one(input int v, input int expv, input string name);
        start = 1'b1; seq_len = 1; tick(); start = 1'b0;
        wait_for(0, name);
        x_valid = 1'b1; x_data = vec4(v, v, v, v); tick(); x_valid = 1'b0;
        wait_for(1, name);
        chk(name, h_data, vec4(expv, expv, expv, expv));
        tick();
        wait_for(2, name);
        tick();
    endtask

    initial begin
        logic [127:0] held;
        int n;
        do_reset();
        armed = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_x_ready", x_ready, 0);
        chk("reset_h_data", h_data, 0);

        // single step
        h_ready = 1'b1;
        start = 1'b1; seq_len = 1; tick(); start = 1'b0;
        chk("t1_x_ready", x_ready, 1);
        chk("t1_busy", busy, 1);
        x_valid = 1'b1; x_data = vec4(1, 2, 3, 4); tick(); x_valid = 1'b0;
        chk("t1_x_ready_low", x_ready, 0);
        tick();
        tick();
        chk("t1_h_valid_early", h_valid, 0);
        tick();
        chk("t1_h_valid", h_valid, 1);
        chk("t1_h_data", h_data, vec4(1, 2, 3, 4));
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_in_done", busy, 1);
        tick();
        chk("t1_done_low", done, 0);
        chk("t1_busy_low", busy, 0);

        // recurrence
        start = 1'b1; seq_len = 3; tick(); start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wait_for(0, "t2_x");
            chk("t2_step_idx", step_idx, s);
            x_valid = 1'b1; x_data = vec4(1, 1, 1, 1); tick(); x_valid = 1'b0;
            wait_for(1, "t2_h");
            chk("t2_h_data", h_data, vec4(s + 1, s + 1, s + 1, s + 1));
            tick();
        end
        chk("t2_done", done, 1);
        tick();

        // backpressure
        h_ready = 1'b0;
        start = 1'b1; seq_len = 1; tick(); start = 1'b0;
        x_valid = 1'b1; x_data = vec4(2, 2, 2, 2); tick(); x_valid = 1'b0;
        wait_for(1, "t3_h");
        held = h_data;
        chk("t3_h_data", held, vec4(2, 2, 2, 2));
        repeat (5) begin
            tick();
            chk("t3_h_valid_held", h_valid, 1);
            chk("t3_h_data_held", h_data, vec4(2, 2, 2, 2));
            chk("t3_no_x_ready", x_ready, 0);
        end
        h_ready = 1'b1; tick();
        chk("t3_done", done, 1);
        tick();

        // zero length
        start = 1'b1; seq_len = 0; tick(); start = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_x_ready", x_ready, 0);
        tick();
        chk("t4_done_low", done, 0);
        chk("t4_busy_low", busy, 0);

        // reset during SETTLE of step 1
        start = 1'b1; seq_len = 3; tick(); start = 1'b0;
        wait_for(0, "t5_x0");
        x_valid = 1'b1; x_data = vec4(7, 7, 7, 7); tick(); x_valid = 1'b0;
        wait_for(1, "t5_h0"); tick();
        wait_for(0, "t5_x1");
        x_valid = 1'b1; tick(); x_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_h_valid", h_valid, 0);
        chk("t5_x_ready", x_ready, 0);
        chk("t5_done", done, 0);
        chk("t5_step_idx", step_idx, 0);
        chk("t5_h_data", h_data, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t5_no_done", done, 0);

        // start ignored while busy
        start = 1'b1; seq_len = 2; tick();
        seq_len = 9;
        x_valid = 1'b1; x_data = vec4(3, 3, 3, 3);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (h_valid) n++;
            tick();
            if (done) break;
        end
        start = 1'b0; x_valid = 1'b0;
        chk("t5_ignored_start_steps", n, 2);
        tick();

        // state carry
        do_reset();
        run_one(5, 5, "t6_first");
        run_one(5, CARRY ? 10 : 5, "t6_second");

        // random traffic, checked by the model every cycle
        for (int r = 0; r < 40; r++) begin
            bit got;
            start = 1'b0; x_valid = 1'b0; h_ready = 1'b0;
            n = 0;
            while (busy && n < 50) begin tick(); n++; end
            seq_len = LW'($urandom_range(0, 4));
            start = 1'b1; tick();
            got = 1'b0;
            for (int k = 0; k < 400; k++) begin
                start = ($urandom_range(0, 3) == 0);
                seq_len = LW'($urandom_range(0, 7));
                x_valid = $urandom_range(0, 1);
                for (int i = 0; i < VEC; i++) x_data[i] = $urandom;
                h_ready = $urandom_range(0, 1);
                tick();
                if (done) begin got = 1'b1; break; end
            end
            start = 1'b0; x_valid = 1'b0;
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL timeout rand_done r=%0d", r);
            end
            tick();
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
